// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and latency encodings for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned AW_DEF      = 5;
    localparam int unsigned MAX_LAT_DEF = 3;
    localparam int unsigned CW_DEF      = 2;

    localparam int unsigned LAT_NONE = 0;
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    function automatic int unsigned clamp_lat(input int unsigned lat,
                                              input int unsigned max_lat);
        return (lat > max_lat) ? max_lat : lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and stall/issue response bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 2
) ();

    logic          id_valid_i;
    logic [AW-1:0] id_rs_i;
    logic [AW-1:0] id_rt_i;
    logic          id_rs_used_i;
    logic          id_rt_used_i;
    logic          id_wr_i;
    logic [AW-1:0] id_rd_i;
    logic [CW-1:0] id_lat_i;
    logic          flush_i;
    logic          stall_o;
    logic          issue_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i,
               id_wr_i, id_rd_i, id_lat_i, flush_i,
        input  stall_o, issue_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i,
               id_wr_i, id_rd_i, id_lat_i, flush_i,
        output stall_o, issue_o
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard cell: countdown of cycles until a register's pending result is forwardable.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] lat_i,
    output logic [CW-1:0] cnt_o,
    output logic          busy_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // A fresh issue overrides the decrement of the older pending write.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = lat_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard at ID: stalls on RAW and WAW hazards for mixed result latencies.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned MAX_LAT = MAX_LAT_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned SCW     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_scoreboard_if.slave id_if,
    output logic [NREG-1:0]   busy_o,
    output logic [SCW-1:0]    stall_cnt_o
);

    logic [CW-1:0]  cnt [NREG];
    logic [CW-1:0]  lat_eff;
    logic           raw;
    logic           waw;
    logic           stall;
    logic           issue;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    assign lat_eff = CW'(clamp_lat(32'(id_if.id_lat_i), MAX_LAT));

    // A count of 1 means the producer reaches the EX/MEM bypass in time for this reader.
    assign raw = (id_if.id_rs_used_i && (id_if.id_rs_i != '0) && (cnt[id_if.id_rs_i] > CW'(1))) ||
                 (id_if.id_rt_used_i && (id_if.id_rt_i != '0) && (cnt[id_if.id_rt_i] > CW'(1)));

    assign waw = id_if.id_wr_i && (id_if.id_rd_i != '0) && (cnt[id_if.id_rd_i] > lat_eff);

    assign stall = id_if.id_valid_i && !id_if.flush_i && (raw || waw);
    assign issue = id_if.id_valid_i && !id_if.flush_i && !stall;

    assign id_if.stall_o = stall;
    assign id_if.issue_o = issue;

    for (genvar r = 0; r < NREG; r++) begin : g_entry
        if (r == 0) begin : g_zero
            assign cnt[r]    = '0;
            assign busy_o[r] = 1'b0;
        end else begin : g_cell
            sb_entry #(
                .CW (CW)
            ) u_entry (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load_i (issue && id_if.id_wr_i && (id_if.id_rd_i == AW'(r))),
                .lat_i  (lat_eff),
                .cnt_o  (cnt[r]),
                .busy_o (busy_o[r])
            );
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: driver queues expected outputs, monitor compares at negedge.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    typedef struct {
        int          id;
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic [3:0]  scnt;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic [31:0] busy;
    logic [3:0]  stall_cnt;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_id = 0;

    hazard_scoreboard_if #(.AW(5), .CW(2)) sb_if ();

    hazard_scoreboard #(
        .NREG    (32),
        .AW      (5),
        .MAX_LAT (3),
        .CW      (2),
        .SCW     (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .id_if       (sb_if),
        .busy_o      (busy),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic cyc(input logic rst, input logic v,
                       input int rs, input logic rsu, input int rt, input logic rtu,
                       input logic wr, input int rd, input int lat, input logic fl,
                       input logic chk, input logic es, input logic ei,
                       input logic [31:0] eb, input int esc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i              = rst;
        sb_if.id_valid_i   = v;
        sb_if.id_rs_i      = 5'(rs);
        sb_if.id_rs_used_i = rsu;
        sb_if.id_rt_i      = 5'(rt);
        sb_if.id_rt_used_i = rtu;
        sb_if.id_wr_i      = wr;
        sb_if.id_rd_i      = 5'(rd);
        sb_if.id_lat_i     = 2'(lat);
        sb_if.flush_i      = fl;
        cyc_id++;
        if (chk) begin
            e.id    = cyc_id;
            e.stall = es;
            e.issue = ei;
            e.busy  = eb;
            e.scnt  = 4'(esc);
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic [31:0] eb, input int esc);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, eb, esc);
    endtask

    task automatic cmp(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, id, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("stall_o", e.id, 32'(sb_if.stall_o), 32'(e.stall));
                cmp("issue_o", e.id, 32'(sb_if.issue_o), 32'(e.issue));
                cmp("busy_o", e.id, busy, e.busy);
                cmp("stall_cnt_o", e.id, 32'(stall_cnt), 32'(e.scnt));
            end
        end
    end

    initial begin : driver
        rst_i              = 1'b1;
        sb_if.id_valid_i   = 1'b0;
        sb_if.id_rs_i      = '0;
        sb_if.id_rt_i      = '0;
        sb_if.id_rs_used_i = 1'b0;
        sb_if.id_rt_used_i = 1'b0;
        sb_if.id_wr_i      = 1'b0;
        sb_if.id_rd_i      = '0;
        sb_if.id_lat_i     = '0;
        sb_if.flush_i      = 1'b0;

        // Reset with a valid writer present: the write must not reach the scoreboard.
        cyc(1, 1, 1, 1, 2, 1, 1, 5, 3, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 2, 1, 1, 5, 3, 0, 1, 0, 1, 0, 0);

        // Load-use: one stall, then issue.
        cyc(0, 1, 29, 1, 0, 0, 1, 8, LAT_LOAD, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 8, 1, 0, 1, 1, 11, LAT_ALU, 0, 1, 1, 0, b(8), 0);
        cyc(0, 1, 8, 1, 0, 1, 1, 11, LAT_ALU, 0, 1, 0, 1, b(8), 1);

        // ALU back-to-back: readers of a lat=1 result never stall.
        cyc(0, 1, 1, 1, 11, 1, 1, 9, LAT_ALU, 0, 1, 0, 1, b(11), 1);
        cyc(0, 1, 9, 1, 9, 1, 0, 0, 0, 0, 1, 0, 1, b(9), 1);
        idle(0, 1);

        // WAW: lat=3 write then lat=1 write to $10.
        cyc(0, 1, 0, 1, 0, 1, 1, 10, 3, 0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 10, LAT_ALU, 0, 1, 1, 0, b(10), 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 10, LAT_ALU, 0, 1, 1, 0, b(10), 2);
        cyc(0, 1, 0, 0, 0, 0, 1, 10, LAT_ALU, 0, 1, 0, 1, b(10), 3);
        idle(b(10), 3);
        idle(0, 3);

        // Zero-latency write leaves the entry idle.
        cyc(0, 1, 0, 0, 0, 0, 1, 12, LAT_NONE, 0, 1, 0, 1, 0, 3);
        idle(0, 3);

        // Flush: hazard suppressed, older counter drains, no new load for $14.
        cyc(0, 1, 0, 0, 0, 0, 1, 13, 3, 0, 1, 0, 1, 0, 3);
        cyc(0, 1, 13, 1, 0, 0, 1, 14, LAT_LOAD, 1, 1, 0, 0, b(13), 3);
        idle(b(13), 3);
        idle(b(13), 3);
        idle(0, 3);

        // Register $0 is never tracked.
        cyc(0, 1, 0, 0, 0, 0, 1, 0, LAT_LOAD, 0, 1, 0, 1, 0, 3);
        cyc(0, 1, 0, 1, 0, 1, 1, 0, 3, 0, 1, 0, 1, 0, 3);

        // rt-only hazard, and an unused rs naming a busy register.
        cyc(0, 1, 0, 0, 0, 0, 1, 15, 3, 0, 1, 0, 1, 0, 3);
        cyc(0, 1, 0, 0, 15, 1, 0, 0, 0, 0, 1, 1, 0, b(15), 3);
        cyc(0, 1, 15, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, b(15), 4);
        idle(b(15), 4);
        idle(0, 4);

        // Reset clears the statistics; then drive the 4-bit counter into saturation.
        cyc(1, 1, 0, 0, 0, 0, 1, 21, 3, 0, 1, 0, 1, 0, 4);
        idle(0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 1, 20, 3, 0, 1, 0, 1, 0, sat(2 * i));
            cyc(0, 1, 20, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, b(20), sat(2 * i));
            cyc(0, 1, 20, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, b(20), sat(2 * i + 1));
            cyc(0, 1, 20, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, b(20), sat(2 * i + 2));
        end
        idle(0, 15);

        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
